// File: rtl/project1.sv
`timescale 1ns/1ps
// project1: 640x480 VGA test-pattern generator with LED/seven-segment switch readback.
// Define FRAME_COUNTER_DISPLAY_EN to show a 16-bit frame counter on HEX3..HEX0.
module project1 #(
   parameter logic [9:0] hVisible   = 10'd640,
   parameter logic [9:0] hSyncStart = 10'd656,
   parameter logic [9:0] hSyncEnd   = 10'd751,
   parameter logic [9:0] hTotal     = 10'd800,
   parameter logic [9:0] vVisible   = 10'd480,
   parameter logic [9:0] vSyncStart = 10'd490,
   parameter logic [9:0] vSyncEnd   = 10'd491,
   parameter logic [9:0] vTotal     = 10'd525
) (
   input  logic       CLOCK_50,
   input  logic [3:0] KEY,
   input  logic [9:0] SW,
   output logic [9:0] LEDR,
   output logic [6:0] HEX0,
   output logic [6:0] HEX1,
   output logic [6:0] HEX2,
   output logic [6:0] HEX3,
   output logic [6:0] HEX4,
   output logic [6:0] HEX5,
   output logic       VGA_CLK,
   output logic       VGA_HS,
   output logic       VGA_VS,
   output logic       VGA_BLANK_N,
   output logic       VGA_SYNC_N,
   output logic [7:0] VGA_R,
   output logic [7:0] VGA_G,
   output logic [7:0] VGA_B
);

   logic       rst;
   logic       pixEn;
   logic [9:0] hCount;
   logic [9:0] vCount;
   logic       hLast;
   logic       vLast;
   logic       visible;
   logic [2:0] bar;
   logic [7:0] rNext;
   logic [7:0] gNext;
   logic [7:0] bNext;
   logic       unusedKeys;

   function automatic logic [6:0] hexSeg(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'h0:    s = 7'b1000000;
         4'h1:    s = 7'b1111001;
         4'h2:    s = 7'b0100100;
         4'h3:    s = 7'b0110000;
         4'h4:    s = 7'b0011001;
         4'h5:    s = 7'b0010010;
         4'h6:    s = 7'b0000010;
         4'h7:    s = 7'b1111000;
         4'h8:    s = 7'b0000000;
         4'h9:    s = 7'b0010000;
         4'hA:    s = 7'b0001000;
         4'hB:    s = 7'b0000011;
         4'hC:    s = 7'b1000110;
         4'hD:    s = 7'b0100001;
         4'hE:    s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   assign unusedKeys = ^KEY[3:1];
   assign VGA_SYNC_N = 1'b0;
   assign VGA_CLK    = pixEn;

   // Pushbutton is active-low; one register stage gives the synchronous reset.
   always_ff @(posedge CLOCK_50) begin
      rst <= ~KEY[0];
   end

   always_ff @(posedge CLOCK_50) begin
      if (rst) pixEn <= 1'b0;
      else     pixEn <= ~pixEn;
   end

   assign hLast = (hCount == hTotal - 10'd1);
   assign vLast = (vCount == vTotal - 10'd1);

   always_ff @(posedge CLOCK_50) begin
      if (rst) begin
         hCount <= '0;
         vCount <= '0;
      end else if (pixEn) begin
         if (hLast) begin
            hCount <= '0;
            vCount <= vLast ? 10'd0 : vCount + 10'd1;
         end else begin
            hCount <= hCount + 10'd1;
         end
      end
   end

   assign visible = (hCount < hVisible) && (vCount < vVisible);

   // Bar index is hcount/80, built from compares instead of a divider.
   always_comb begin
      bar = 3'd7;
      if      (hCount < 10'd80)  bar = 3'd0;
      else if (hCount < 10'd160) bar = 3'd1;
      else if (hCount < 10'd240) bar = 3'd2;
      else if (hCount < 10'd320) bar = 3'd3;
      else if (hCount < 10'd400) bar = 3'd4;
      else if (hCount < 10'd480) bar = 3'd5;
      else if (hCount < 10'd560) bar = 3'd6;
   end

   always_comb begin
      rNext = 8'h00;
      gNext = 8'h00;
      bNext = 8'h00;
      case (SW[9:8])
         2'b00: begin
            rNext = {8{SW[2]}};
            gNext = {8{SW[1]}};
            bNext = {8{SW[0]}};
         end
         2'b01: begin
            rNext = {8{bar[2]}};
            gNext = {8{bar[1]}};
            bNext = {8{bar[0]}};
         end
         2'b10: begin
            rNext = {8{hCount[5] ^ vCount[5]}};
            gNext = {8{hCount[5] ^ vCount[5]}};
            bNext = {8{hCount[5] ^ vCount[5]}};
         end
         default: begin
            rNext = hCount[9:2];
            gNext = hCount[9:2];
            bNext = hCount[9:2];
         end
      endcase
   end

   // Sync, blank and colour all sample the same counter values so they stay aligned.
   always_ff @(posedge CLOCK_50) begin
      if (rst) begin
         VGA_HS      <= 1'b1;
         VGA_VS      <= 1'b1;
         VGA_BLANK_N <= 1'b0;
         VGA_R       <= 8'h00;
         VGA_G       <= 8'h00;
         VGA_B       <= 8'h00;
         LEDR        <= '0;
      end else begin
         VGA_HS      <= ~((hCount >= hSyncStart) && (hCount <= hSyncEnd));
         VGA_VS      <= ~((vCount >= vSyncStart) && (vCount <= vSyncEnd));
         VGA_BLANK_N <= visible;
         VGA_R       <= visible ? rNext : 8'h00;
         VGA_G       <= visible ? gNext : 8'h00;
         VGA_B       <= visible ? bNext : 8'h00;
         LEDR        <= SW;
      end
   end

   assign HEX5 = hexSeg(SW[7:4]);
   assign HEX4 = hexSeg(SW[3:0]);

`ifdef FRAME_COUNTER_DISPLAY_EN
   logic [15:0] frameCount;

   always_ff @(posedge CLOCK_50) begin
      if (rst)                          frameCount <= '0;
      else if (pixEn && hLast && vLast) frameCount <= frameCount + 16'd1;
   end

   assign HEX0 = hexSeg(frameCount[3:0]);
   assign HEX1 = hexSeg(frameCount[7:4]);
   assign HEX2 = hexSeg(frameCount[11:8]);
   assign HEX3 = hexSeg(frameCount[15:12]);
`else
   assign HEX0 = 7'b1111111;
   assign HEX1 = 7'b1111111;
   assign HEX2 = 7'b1111111;
   assign HEX3 = 7'b1111111;
`endif

endmodule

// File: tb/tb_project1.sv
`timescale 1ns/1ps
// tb_project1: self-checking bench for the VGA pattern generator.
// Vertical geometry is shortened (8 lines, 4 visible, sync on lines 5..6) so whole frames fit in a short run.
module tb_project1;

  localparam int H_TOTAL      = 800;
  localparam int H_VISIBLE    = 640;
  localparam int H_SYNC_START = 656;
  localparam int H_SYNC_END   = 751;
  localparam int V_VISIBLE    = 4;
  localparam int V_SYNC_START = 5;
  localparam int V_SYNC_END   = 6;
  localparam int V_TOTAL      = 8;
  localparam int FRAME_PIX    = H_TOTAL * V_TOTAL;
  localparam int FRAME_EDGES  = 2 * FRAME_PIX;

`ifdef FRAME_COUNTER_DISPLAY_EN
  localparam bit FC_EN = 1'b1;
`else
  localparam bit FC_EN = 1'b0;
`endif

  typedef struct {
    int         f;
    int         v;
    int         h;
    logic [9:0] sw;
  } pixStim_t;

  logic       CLOCK_50 = 1'b0;
  logic [3:0] KEY = 4'b1111;
  logic [9:0] SW = '0;
  logic [9:0] LEDR;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic       VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N;
  logic [7:0] VGA_R, VGA_G, VGA_B;

  int errors = 0;
  int checks = 0;
  int edgeNum = 0;
  int relEdge = 0;
  logic [26:0] expQ[$];
  pixStim_t stimQ[$];

  project1 #(
    .vVisible(10'd4), .vSyncStart(10'd5), .vSyncEnd(10'd6), .vTotal(10'd8)
  ) dut (
    .CLOCK_50(CLOCK_50), .KEY(KEY), .SW(SW), .LEDR(LEDR),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5),
    .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
    .VGA_BLANK_N(VGA_BLANK_N), .VGA_SYNC_N(VGA_SYNC_N),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
  );

  // Clock / edge counter
  always #10 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) edgeNum <= edgeNum + 1;

  initial begin
    #1800000;
    $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [6:0] segOf(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'b1000000;  4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;  4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;  4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;  4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;  4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;  4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;  4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;  default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Expected {HS, VS, BLANK_N, R, G, B} for pixel (h, v) under switch setting sw.
  function automatic logic [26:0] pixelModel(input logic [9:0] sw, input int h, input int v);
    logic [7:0] r, g, b;
    logic vis, hs, vs;
    int bar;
    r = 8'h00; g = 8'h00; b = 8'h00;
    vis = (h < H_VISIBLE) && (v < V_VISIBLE);
    hs = !((h >= H_SYNC_START) && (h <= H_SYNC_END));
    vs = !((v >= V_SYNC_START) && (v <= V_SYNC_END));
    bar = h / 80;
    if (vis) begin
      case (sw[9:8])
        2'b00: begin
          r = sw[2] ? 8'hFF : 8'h00;
          g = sw[1] ? 8'hFF : 8'h00;
          b = sw[0] ? 8'hFF : 8'h00;
        end
        2'b01: begin
          r = ((bar & 4) != 0) ? 8'hFF : 8'h00;
          g = ((bar & 2) != 0) ? 8'hFF : 8'h00;
          b = ((bar & 1) != 0) ? 8'hFF : 8'h00;
        end
        2'b10: begin
          if (((h >> 5) & 1) != ((v >> 5) & 1)) begin
            r = 8'hFF; g = 8'hFF; b = 8'hFF;
          end
        end
        default: begin
          r = 8'(h / 4); g = 8'(h / 4); b = 8'(h / 4);
        end
      endcase
    end
    return {hs, vs, vis, r, g, b};
  endfunction

  function automatic logic sigSel(input int sel);
    case (sel)
      0:       return VGA_CLK;
      1:       return VGA_HS;
      default: return VGA_VS;
    endcase
  endfunction

  // Driver tasks
  task automatic waitLevel(input int sel, input logic level, input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLOCK_50);
      if (sigSel(sel) === level) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic waitRel(input int k);
    while (edgeNum < relEdge + k) @(negedge CLOCK_50);
  endtask

  task automatic releaseReset();
    KEY[0] = 1'b1;
    relEdge = edgeNum + 1;
  endtask

  task automatic test_reset();
    SW = 10'h3FF;
    @(negedge CLOCK_50);
    KEY = {3'($urandom_range(0, 7)), 1'b0};
    repeat (10) @(negedge CLOCK_50);
    checks++; if (VGA_CLK !== 1'b0) begin errors++; $display("FAIL reset_vga_clk: got %b want 0", VGA_CLK); end
    checks++; if (VGA_HS !== 1'b1) begin errors++; $display("FAIL reset_hs: got %b want 1", VGA_HS); end
    checks++; if (VGA_VS !== 1'b1) begin errors++; $display("FAIL reset_vs: got %b want 1", VGA_VS); end
    checks++; if (VGA_BLANK_N !== 1'b0) begin errors++; $display("FAIL reset_blank_n: got %b want 0", VGA_BLANK_N); end
    checks++; if ({VGA_R, VGA_G, VGA_B} !== 24'h0) begin errors++; $display("FAIL reset_rgb: got %h want 000000", {VGA_R, VGA_G, VGA_B}); end
    checks++; if (LEDR !== 10'h0) begin errors++; $display("FAIL reset_ledr: got %h want 000", LEDR); end
    checks++; if (VGA_SYNC_N !== 1'b0) begin errors++; $display("FAIL sync_n: got %b want 0", VGA_SYNC_N); end
    checks++;
    if ({HEX3, HEX2, HEX1, HEX0} !== {4{FC_EN ? 7'b1000000 : 7'b1111111}}) begin
      errors++; $display("FAIL reset_hex_low: got %h want %h", {HEX3, HEX2, HEX1, HEX0}, {4{FC_EN ? 7'b1000000 : 7'b1111111}});
    end
    repeat (20) @(negedge CLOCK_50);
    releaseReset();
  endtask

  task automatic test_timing();
    logic ok;
    longint t1, tFall, tRise;
    waitLevel(0, 1'b1, 10, ok);
    checks++; if (!ok || (edgeNum - relEdge) != 1) begin errors++; $display("FAIL vga_clk_first_rise: ok=%b edge=%0d want 1", ok, edgeNum - relEdge); end
    t1 = $time;
    waitLevel(0, 1'b0, 10, ok);
    waitLevel(0, 1'b1, 10, ok);
    checks++; if (!ok || ($time - t1) != 40) begin errors++; $display("FAIL vga_clk_period: ok=%b got %0d ns want 40", ok, $time - t1); end
    waitLevel(1, 1'b0, 3000, ok);
    checks++; if (!ok || (edgeNum - relEdge) != 2 * H_SYNC_START + 1) begin
      errors++; $display("FAIL hs_first_fall: ok=%b edge=%0d want %0d", ok, edgeNum - relEdge, 2 * H_SYNC_START + 1);
    end
    tFall = $time;
    waitLevel(1, 1'b1, 500, ok);
    tRise = $time;
    checks++; if (!ok || (tRise - tFall) != 3840) begin errors++; $display("FAIL hs_low_width: ok=%b got %0d ns want 3840", ok, tRise - tFall); end
    waitLevel(1, 1'b0, 2000, ok);
    checks++; if (!ok || ($time - tFall) != 32000) begin errors++; $display("FAIL hs_period: ok=%b got %0d ns want 32000", ok, $time - tFall); end
  endtask

  task automatic test_vsync();
    logic ok;
    longint tFall;
    waitLevel(2, 1'b0, 20000, ok);
    checks++; if (!ok || (edgeNum - relEdge) != 2 * V_SYNC_START * H_TOTAL + 1) begin
      errors++; $display("FAIL vs_first_fall: ok=%b edge=%0d want %0d", ok, edgeNum - relEdge, 2 * V_SYNC_START * H_TOTAL + 1);
    end
    tFall = $time;
    waitLevel(2, 1'b1, 5000, ok);
    checks++; if (!ok || ($time - tFall) != 64000) begin errors++; $display("FAIL vs_low_width: ok=%b got %0d ns want 64000", ok, $time - tFall); end
    waitLevel(2, 1'b0, 20000, ok);
    checks++; if (!ok || ($time - tFall) != longint'(FRAME_EDGES) * 20) begin
      errors++; $display("FAIL vs_period: ok=%b got %0d ns want %0d", ok, $time - tFall, FRAME_EDGES * 20);
    end
  endtask

  task automatic test_switch_display();
    logic [9:0] sw;
    for (int i = 0; i < 17; i++) begin
      sw = (i == 16) ? 10'h0A5 : {2'($urandom_range(0, 3)), 4'(i), 4'(15 - i)};
      SW = sw;
      repeat (2) @(negedge CLOCK_50);
      checks++; if (LEDR !== sw) begin errors++; $display("FAIL ledr: got %h want %h", LEDR, sw); end
      checks++; if (HEX5 !== segOf(sw[7:4])) begin errors++; $display("FAIL hex5: got %b want %b", HEX5, segOf(sw[7:4])); end
      checks++; if (HEX4 !== segOf(sw[3:0])) begin errors++; $display("FAIL hex4: got %b want %b", HEX4, segOf(sw[3:0])); end
    end
  endtask

  task automatic test_frame_counter();
    logic [27:0] want;
    waitRel(3 * FRAME_EDGES - 10);
    want = FC_EN ? {segOf(4'h0), segOf(4'h0), segOf(4'h0), segOf(4'h2)} : {4{7'b1111111}};
    checks++; if ({HEX3, HEX2, HEX1, HEX0} !== want) begin errors++; $display("FAIL frame_before_wrap: got %h want %h", {HEX3, HEX2, HEX1, HEX0}, want); end
    waitRel(3 * FRAME_EDGES + 10);
    want = FC_EN ? {segOf(4'h0), segOf(4'h0), segOf(4'h0), segOf(4'h3)} : {4{7'b1111111}};
    checks++; if ({HEX3, HEX2, HEX1, HEX0} !== want) begin errors++; $display("FAIL frame_after_wrap: got %h want %h", {HEX3, HEX2, HEX1, HEX0}, want); end
    KEY[0] = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    want = FC_EN ? {4{segOf(4'h0)}} : {4{7'b1111111}};
    checks++; if ({HEX3, HEX2, HEX1, HEX0} !== want) begin errors++; $display("FAIL frame_reset_clear: got %h want %h", {HEX3, HEX2, HEX1, HEX0}, want); end
    releaseReset();
  endtask

  // Scoreboard: expected pixel pushed as SW is driven, popped when that pixel is on the outputs.
  task automatic test_pixels();
    pixStim_t s;
    logic [26:0] got, exp;
    int n;
    stimQ.delete();
    foreach (stimQ[i]) stimQ.delete(i);
    stimQ.push_back('{0, 0, 79, 10'h100});  stimQ.push_back('{0, 0, 80, 10'h100});
    stimQ.push_back('{0, 0, 85, 10'h100});  stimQ.push_back('{0, 0, 500, 10'h100});
    stimQ.push_back('{0, 0, 600, 10'h100}); stimQ.push_back('{0, 0, 639, 10'h100});
    stimQ.push_back('{0, 0, 640, 10'h100});
    stimQ.push_back('{0, 1, 10, 10'h0A5});  stimQ.push_back('{0, 1, 320, 10'h0A5});
    stimQ.push_back('{0, 1, 639, 10'h0A5}); stimQ.push_back('{0, 1, 700, 10'h0A5});
    stimQ.push_back('{0, 2, 399, 10'h300}); stimQ.push_back('{0, 2, 400, 10'h300});
    stimQ.push_back('{0, 2, 655, 10'h300}); stimQ.push_back('{0, 2, 656, 10'h300});
    stimQ.push_back('{0, 2, 751, 10'h300}); stimQ.push_back('{0, 2, 752, 10'h300});
    stimQ.push_back('{0, 3, 31, 10'h200});  stimQ.push_back('{0, 3, 32, 10'h200});
    stimQ.push_back('{0, 3, 63, 10'h200});  stimQ.push_back('{0, 3, 64, 10'h200});
    stimQ.push_back('{0, 3, 100, 10'h007}); stimQ.push_back('{0, 3, 101, 10'h000});
    stimQ.push_back('{0, 3, 102, 10'h300});
    stimQ.push_back('{0, 4, 10, 10'h300});  stimQ.push_back('{0, 5, 10, 10'h300});
    stimQ.push_back('{0, 6, 799, 10'h300}); stimQ.push_back('{0, 7, 0, 10'h300});
    for (int v = 0; v < V_VISIBLE; v++) begin
      stimQ.push_back('{1, v, $urandom_range(0, 399), 10'($urandom_range(0, 1023))});
      stimQ.push_back('{1, v, $urandom_range(400, 799), 10'($urandom_range(0, 1023))});
    end
    while (stimQ.size() > 0) begin
      s = stimQ.pop_front();
      n = s.f * FRAME_PIX + s.v * H_TOTAL + s.h;
      SW = s.sw;
      expQ.push_back(pixelModel(s.sw, s.h, s.v));
      waitRel(2 * n + 2);
      got = {VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B};
      exp = expQ.pop_front();
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL pixel f%0d v%0d h%0d sw=%h: got %h want %h", s.f, s.v, s.h, s.sw, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [26:0] got, exp;
    SW = 10'h300;
    KEY[0] = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    checks++;
    if ({VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B, LEDR} !== {4'b0110, 24'h0, 10'h0}) begin
      errors++; $display("FAIL mid_reset_outputs: got %h want %h",
        {VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B, LEDR}, {4'b0110, 24'h0, 10'h0});
    end
    repeat (2) @(negedge CLOCK_50);
    releaseReset();
    foreach (stimQ[i]) stimQ.delete(i);
    for (int h = 4; h < 800; h += 748) begin
      expQ.push_back(pixelModel(SW, h, 0));
      waitRel(2 * h + 2);
      got = {VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B};
      exp = expQ.pop_front();
      checks++;
      if (got !== exp) begin errors++; $display("FAIL restart_pixel h%0d: got %h want %h", h, got, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_vsync();
    test_switch_display();
    test_frame_counter();
    test_pixels();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
